axi_read_master_mo: RTL
=======================

Name: axi_read_master_mo

Overview:
Next-generation AXI4 read master with a parametrised data width and multiple outstanding bursts. Takes a system read request of arbitrary beat count and splits it into AXI INCR bursts at MAX_BURST_LEN and 4 KB boundaries. Issues bursts under an outstanding-burst credit limit. Returns read data through a registered skid stage with per-beat ID, response and error indication. Sits between DMA/queue logic and the AXI interconnect, alongside the existing write master.

Parameters:
DATA_WIDTH, 128, bus data width in bits; power of 2, 32..512; BYTES = DATA_WIDTH/8
ADDR_WIDTH, 64, address width
ID_WIDTH, 4, AXI ID width
MAX_OUTSTANDING, 8, maximum bursts in flight; power of 2, 1..64
MAX_BURST_LEN, 256, maximum beats per AXI burst; 1..256
ENFORCE_4K, 1, when 1, bursts never cross a 4 KB boundary

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted on valid&ready
req_addr  in  ADDR_WIDTH  start byte address; bits below log2(BYTES) ignored
req_beats  in  16  beat count
req_id  in  ID_WIDTH  ID used on every burst of the request
req_cache  in  4  AxCACHE value
bus_arvalid / bus_arready  out/in  1  AR handshake
bus_araddr  out  ADDR_WIDTH  burst address
bus_arlen  out  8  beats-1
bus_arsize  out  3  log2(BYTES)
bus_arburst  out  2  constant 2'b01 (INCR)
bus_arcache  out  4  latched req_cache
bus_arprot  out  3  constant 3'b000
bus_arid  out  ID_WIDTH  latched req_id
bus_rvalid / bus_rready  in/out  1  R handshake
bus_rdata  in  DATA_WIDTH  read data
bus_rresp  in  2  read response
bus_rlast  in  1  last beat of burst
bus_rid  in  ID_WIDTH  response ID
rd_valid / rd_ready  out/in  1  user data handshake
rd_data  out  DATA_WIDTH  data
rd_id  out  ID_WIDTH  bus_rid of the beat
rd_resp  out  2  bus_rresp of the beat
rd_last  out  1  bus_rlast of the beat
rd_err  out  1  one-cycle pulse per accepted beat with rresp[1]=1
outstanding  out  $clog2(MAX_OUTSTANDING)+1  bursts in flight
busy  out  1  splitter not IDLE or outstanding != 0

Behaviour:
- Reset: all outputs 0 except bus_arburst=2'b01 and bus_arsize=log2(BYTES). req_ready rises 1 cycle after reset_n deasserts.
- Reset mid-operation clears the FSM, the credit counter and the skid buffer. In-flight bus state is discarded; the slave must be reset too.
- Splitter FSM, IDLE -> ISSUE -> IDLE:
  - IDLE: req_ready=1. On acceptance, latch addr (aligned), beats, id and cache.
  - req_beats=0: accepted, no bus traffic, stay IDLE.
  - ISSUE: n = min(remaining, MAX_BURST_LEN, (4096-addr[11:0])/BYTES when ENFORCE_4K). Drive arlen=n-1.
  - bus_arvalid is asserted only when outstanding < MAX_OUTSTANDING. Once asserted, all AR fields stay stable until bus_arready.
  - On each AR handshake: addr += n*BYTES (mod 2^ADDR_WIDTH), remaining -= n. When remaining reaches 0, go to IDLE.
  - Next AR may be issued in the cycle after the handshake.
- Credit counter: +1 on AR handshake, -1 on R handshake with rlast; both in the same cycle leaves it unchanged.
- R path: 2-entry skid buffer with 1-cycle latency from R handshake to rd_valid.
  - bus_rready is registered: high when the buffer has a free entry.
  - No beat is lost or duplicated. Order is preserved; out-of-order IDs pass through unchanged.
- rd_err asserts in the cycle the erroring beat is presented on rd_*.

Optional Feature:
AXI_RDM_STATS_EN
- Defined: adds input stat_clr and outputs stat_bursts[31:0], stat_beats[31:0], stat_errs[15:0]. These are saturating counters of AR handshakes, R handshakes and rresp[1]=1 beats. stat_clr zeroes them; reset zeroes them.
- Undefined: the ports and logic are absent.

Decomposition:
- Package axi_rdm_pkg: AXI_BURST_INCR, AXI_RESP_* constants, BOUNDARY_4K=4096, and a function computing burst beats.
- Sub-module axi_skid_buf, parameterised by payload width, carries {rdata, rid, rresp, rlast}.

Test Plan:
1. DATA_WIDTH=128, addr 0x1000, 16 beats -> one AR (araddr 0x1000, arlen 15, arsize 4); 16 rd_valid beats with rd_last on the 16th; outstanding goes 1 -> 0.
2. Addr 0x0FC0, 8 beats, ENFORCE_4K=1 -> AR 0x0FC0 arlen 3, then AR 0x1000 arlen 3.
3. Addr 0x0, 600 beats, MAX_BURST_LEN=256 -> arlen 255/255/87 at 0x0/0x1000/0x2000.
4. MAX_OUTSTANDING=2, slave withholds R -> two ARs, then arvalid low and outstanding=2. After the first rlast handshake, the third AR follows.
5. rd_ready low for 5 cycles mid-burst -> bus_rready low within 1 cycle; the beat sequence 0..15 arrives intact.
6. rresp=2'b10 on beat 3 -> rd_err pulses once, rd_resp=2'b10 on that beat, and the burst completes.

Source files
------------

// File: rtl/axi_rdm_pkg.sv
// Shared constants and burst sizing helper for the AXI read master.
package axi_rdm_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam int unsigned BOUNDARY_4K    = 4096;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rdm_state_e;

    // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page.
    function automatic logic [8:0] burst_beats(
        input logic [15:0] remaining,
        input logic [11:0] addr_lo,
        input int unsigned max_len,
        input int unsigned bytes,
        input bit          enforce_4k
    );
        int unsigned n;
        int unsigned room;
        n = 32'(remaining);
        if (n > max_len) n = max_len;
        if (enforce_4k) begin
            room = (BOUNDARY_4K - 32'(addr_lo)) / bytes;
            if (n > room) n = room;
        end
        return n[8:0];
    endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry registered skid buffer; in_ready_o is a flop that is high while an entry is free.
module axi_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             in_ready_q;
    logic             wr_en;
    logic             rd_en;

    assign wr_en       = in_valid_i & in_ready_q;
    assign rd_en       = out_valid_o & out_ready_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign in_ready_o  = in_ready_q;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en)      count_d = count_q + 2'd1;
        else if (!wr_en && rd_en) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_en) rd_ptr_q <= ~rd_ptr_q;
            count_q    <= count_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/axi_read_master_mo.sv
// AXI4 read master: splits requests into INCR bursts under an outstanding-burst credit limit.
// Optional statistics counters are built when AXI_RDM_STATS_EN is defined.
//   state    | meaning
//   ST_IDLE  | req_ready high, waiting for a request
//   ST_ISSUE | issuing AR bursts until the request's beats are exhausted
module axi_read_master_mo
    import axi_rdm_pkg::*;
#(
    parameter int DATA_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int MAX_BURST_LEN   = 256,
    parameter int ENFORCE_4K      = 1
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
`ifdef AXI_RDM_STATS_EN
    input  logic                                 stat_clr,
    output logic [31:0]                          stat_bursts,
    output logic [31:0]                          stat_beats,
    output logic [15:0]                          stat_errs,
`endif
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [15:0]                          req_beats,
    input  logic [ID_WIDTH-1:0]                  req_id,
    input  logic [3:0]                           req_cache,
    output logic                                 bus_arvalid,
    input  logic                                 bus_arready,
    output logic [ADDR_WIDTH-1:0]                bus_araddr,
    output logic [7:0]                           bus_arlen,
    output logic [2:0]                           bus_arsize,
    output logic [1:0]                           bus_arburst,
    output logic [3:0]                           bus_arcache,
    output logic [2:0]                           bus_arprot,
    output logic [ID_WIDTH-1:0]                  bus_arid,
    input  logic                                 bus_rvalid,
    output logic                                 bus_rready,
    input  logic [DATA_WIDTH-1:0]                bus_rdata,
    input  logic [1:0]                           bus_rresp,
    input  logic                                 bus_rlast,
    input  logic [ID_WIDTH-1:0]                  bus_rid,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic [ID_WIDTH-1:0]                  rd_id,
    output logic [1:0]                           rd_resp,
    output logic                                 rd_last,
    output logic                                 rd_err,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW    = DATA_WIDTH + ID_WIDTH + 3;
    localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

    rdm_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           remaining_q;
    logic [7:0]            arlen_q;
    logic                  arvalid_q;
    logic                  req_ready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [3:0]            cache_q;
    logic [OW-1:0]         outstanding_q;
    logic [OW-1:0]         outstanding_d;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  r_last_hs;
    logic                  credit_ok;
    logic [ADDR_WIDTH-1:0] req_addr_al;
    logic [8:0]            beats_cur;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [15:0]           rem_nx;
    logic [8:0]            first_n;
    logic [8:0]            next_n;
    logic [PW-1:0]         skid_out;

    assign ar_hs     = arvalid_q & bus_arready;
    assign r_hs      = bus_rvalid & bus_rready;
    assign r_last_hs = r_hs & bus_rlast;

    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !r_last_hs)      outstanding_d = outstanding_q + 1'b1;
        else if (!ar_hs && r_last_hs) outstanding_d = outstanding_q - 1'b1;
    end

    // Credit is judged on the count after this edge so a freed slot is usable at once.
    assign credit_ok   = (outstanding_d < MAX_OS);
    assign req_addr_al = req_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign beats_cur   = {1'b0, arlen_q} + 9'd1;
    assign addr_nx     = addr_q + (ADDR_WIDTH'(beats_cur) << SIZE);
    assign rem_nx      = remaining_q - 16'(beats_cur);
    assign first_n     = burst_beats(req_beats, req_addr_al[11:0], MAX_BURST_LEN, BYTES,
                                     ENFORCE_4K != 0);
    assign next_n      = burst_beats(rem_nx, addr_nx[11:0], MAX_BURST_LEN, BYTES,
                                     ENFORCE_4K != 0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            req_ready_q <= 1'b0;
            id_q        <= '0;
            cache_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q && (req_beats != 16'd0)) begin
                        state_q     <= ST_ISSUE;
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr_al;
                        remaining_q <= req_beats;
                        arlen_q     <= 8'(first_n - 9'd1);
                        id_q        <= req_id;
                        cache_q     <= req_cache;
                        arvalid_q   <= credit_ok;
                    end
                end
                ST_ISSUE: begin
                    if (ar_hs) begin
                        addr_q      <= addr_nx;
                        remaining_q <= rem_nx;
                        if (rem_nx == 16'd0) begin
                            state_q     <= ST_IDLE;
                            arvalid_q   <= 1'b0;
                            req_ready_q <= 1'b1;
                        end else begin
                            arlen_q   <= 8'(next_n - 9'd1);
                            arvalid_q <= credit_ok;
                        end
                    end else if (!arvalid_q) begin
                        arvalid_q <= credit_ok;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) outstanding_q <= '0;
        else          outstanding_q <= outstanding_d;
    end

    axi_skid_buf #(
        .WIDTH(PW)
    ) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid_i (bus_rvalid),
        .in_ready_o (bus_rready),
        .in_data_i  ({bus_rdata, bus_rid, bus_rresp, bus_rlast}),
        .out_valid_o(rd_valid),
        .out_ready_i(rd_ready),
        .out_data_o (skid_out)
    );

    assign {rd_data, rd_id, rd_resp, rd_last} = skid_out;
    assign rd_err = rd_valid & rd_ready & rd_resp[1];

    assign req_ready   = req_ready_q;
    assign bus_arvalid = arvalid_q;
    assign bus_araddr  = addr_q;
    assign bus_arlen   = arlen_q;
    assign bus_arsize  = 3'(SIZE);
    assign bus_arburst = AXI_BURST_INCR;
    assign bus_arcache = cache_q;
    assign bus_arprot  = 3'b000;
    assign bus_arid    = id_q;
    assign outstanding = outstanding_q;
    assign busy        = (state_q != ST_IDLE) || (outstanding_q != '0);

`ifdef AXI_RDM_STATS_EN
    logic [31:0] stat_bursts_q;
    logic [31:0] stat_beats_q;
    logic [15:0] stat_errs_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_bursts_q <= '0;
            stat_beats_q  <= '0;
            stat_errs_q   <= '0;
        end else if (stat_clr) begin
            stat_bursts_q <= '0;
            stat_beats_q  <= '0;
            stat_errs_q   <= '0;
        end else begin
            if (ar_hs && (stat_bursts_q != '1)) stat_bursts_q <= stat_bursts_q + 32'd1;
            if (r_hs && (stat_beats_q != '1))   stat_beats_q  <= stat_beats_q + 32'd1;
            if (r_hs && bus_rresp[1] && (stat_errs_q != '1))
                stat_errs_q <= stat_errs_q + 16'd1;
        end
    end

    assign stat_bursts = stat_bursts_q;
    assign stat_beats  = stat_beats_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule
